// File: rtl/rv_alu2_pkg.sv
// Shared types and encodings for the rv_alu2 execute stage and its branch comparator.
package rv_alu2_pkg;

    // One-hot result select coming from operand-select; arith is the MSB.
    typedef struct packed {
        logic arith;
        logic lgc;
        logic shift;
        logic slt;
    } alu_res_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2,
        RES_CSR = 2'd3
    } res_src_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRX  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam int ALU_SUB_BIT = 0;

endpackage

// File: rtl/rv_branch_cmp.sv
// Combinational branch-condition evaluator; funct3 010/011 are never taken.
import rv_alu2_pkg::*;

module rv_branch_cmp (
    input  logic [2:0]  funct3,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (op1 == op2);
            F3_BNE:  cond = (op1 != op2);
            F3_BLT:  cond = ($signed(op1) <  $signed(op2));
            F3_BGE:  cond = ($signed(op1) >= $signed(op2));
            F3_BLTU: cond = (op1 <  op2);
            F3_BGEU: cond = (op1 >= op2);
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv_alu2.sv
// Execute stage: integer ALU, branch/jump resolution, redirect and predictor update.
import rv_alu2_pkg::*;

module rv_alu2 #(
    parameter int IADDR_SPACE_BITS = 32
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_stall,
    input  logic                        i_flush,
    input  logic [31:0]                 i_op1,
    input  logic [31:0]                 i_op2,
    input  alu_res_t                    i_res,
    input  logic [2:0]                  i_funct3,
    input  logic [4:0]                  i_alu_sub,
    input  res_src_t                    i_res_src,
    input  logic                        i_reg_write,
    input  logic                        i_store,
    input  logic [4:0]                  i_rd,
    input  logic [31:0]                 i_reg_data2,
    input  logic                        i_inst_jal_jalr,
    input  logic                        i_inst_branch,
    input  logic [IADDR_SPACE_BITS-1:0] i_pc,
    input  logic [IADDR_SPACE_BITS-1:0] i_pc_next,
    input  logic [IADDR_SPACE_BITS-1:0] i_pc_target,
    input  logic                        i_branch_pred,
    input  logic                        i_to_trap,
    output logic [31:0]                 o_result,
    output logic [31:0]                 o_store_data,
    output logic [4:0]                  o_rd,
    output logic                        o_reg_write,
    output logic                        o_store,
    output res_src_t                    o_res_src,
    output logic [2:0]                  o_funct3,
    output logic                        o_to_trap,
    output logic                        o_pc_change,
    output logic [IADDR_SPACE_BITS-1:0] o_pc_new,
    output logic                        o_bp_update,
    output logic                        o_bp_taken,
    output logic [IADDR_SPACE_BITS-1:0] o_bp_pc
);

    logic [31:0]                 alu_p0;
    logic [31:0]                 result_p0;
    logic [4:0]                  shamt_p0;
    logic                        cond_p0;
    logic                        taken_p0;
    logic                        change_p0;
    logic [IADDR_SPACE_BITS-1:0] pc4_p0;
    logic [IADDR_SPACE_BITS-1:0] next_p0;
    logic                        unused_bits;

    // Reserved sub bits, the target LSB and the prediction bit carry no information here.
    assign unused_bits = ^{i_alu_sub[4:1], i_pc_target[0], i_branch_pred};
    assign shamt_p0    = i_op2[4:0];

    rv_branch_cmp u_cmp (
        .funct3 (i_funct3),
        .op1    (i_op1),
        .op2    (i_op2),
        .cond   (cond_p0)
    );

    // Stage p0: combinational execute
    always_comb begin
        alu_p0 = '0;
        if (i_res.arith) begin
            alu_p0 = i_alu_sub[ALU_SUB_BIT] ? (i_op1 - i_op2) : (i_op1 + i_op2);
        end else if (i_res.lgc) begin
            case (i_funct3)
                F3_XOR:  alu_p0 = i_op1 ^ i_op2;
                F3_OR:   alu_p0 = i_op1 | i_op2;
                F3_AND:  alu_p0 = i_op1 & i_op2;
                default: alu_p0 = '0;
            endcase
        end else if (i_res.shift) begin
            case (i_funct3)
                F3_SLL:  alu_p0 = i_op1 << shamt_p0;
                F3_SRX:  alu_p0 = i_alu_sub[ALU_SUB_BIT] ? 32'($signed(i_op1) >>> shamt_p0)
                                                         : (i_op1 >> shamt_p0);
                default: alu_p0 = '0;
            endcase
        end else if (i_res.slt) begin
            case (i_funct3)
                F3_SLT:  alu_p0 = {31'b0, $signed(i_op1) < $signed(i_op2)};
                F3_SLTU: alu_p0 = {31'b0, i_op1 < i_op2};
                default: alu_p0 = '0;
            endcase
        end
    end

    assign pc4_p0    = i_pc + IADDR_SPACE_BITS'(4);
    assign result_p0 = i_inst_jal_jalr ? 32'(pc4_p0) : alu_p0;
    assign taken_p0  = i_inst_jal_jalr | (i_inst_branch & cond_p0);
    assign next_p0   = taken_p0 ? {i_pc_target[IADDR_SPACE_BITS-1:1], 1'b0} : pc4_p0;
    assign change_p0 = (i_inst_jal_jalr | i_inst_branch) & (next_p0 != i_pc_next) & ~i_to_trap;

    // Stage p1: registered outputs towards memory/writeback
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_result     <= '0;
            o_store_data <= '0;
            o_rd         <= '0;
            o_reg_write  <= 1'b0;
            o_store      <= 1'b0;
            o_res_src    <= RES_ALU;
            o_funct3     <= '0;
            o_to_trap    <= 1'b0;
            o_pc_change  <= 1'b0;
            o_pc_new     <= '0;
            o_bp_update  <= 1'b0;
            o_bp_taken   <= 1'b0;
            o_bp_pc      <= '0;
        end else if (i_flush) begin
            o_reg_write  <= 1'b0;
            o_store      <= 1'b0;
            o_res_src    <= RES_ALU;
            o_to_trap    <= 1'b0;
            o_pc_change  <= 1'b0;
            o_bp_update  <= 1'b0;
        end else if (i_stall) begin
            o_pc_change  <= 1'b0;
            o_bp_update  <= 1'b0;
        end else begin
            o_result     <= result_p0;
            o_store_data <= i_reg_data2;
            o_rd         <= i_rd;
            o_reg_write  <= i_reg_write;
            o_store      <= i_store;
            o_res_src    <= i_res_src;
            o_funct3     <= i_funct3;
            o_to_trap    <= i_to_trap;
            o_pc_change  <= change_p0;
            o_pc_new     <= next_p0;
            o_bp_update  <= i_inst_branch | i_inst_jal_jalr;
            o_bp_taken   <= taken_p0;
            o_bp_pc      <= i_pc;
        end
    end

endmodule

// File: tb/tb_rv_alu2.sv
// Directed self-checking bench for rv_alu2 with hand-computed expectations.
import rv_alu2_pkg::*;

module tb_rv_alu2;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_stall;
    logic        i_flush;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    alu_res_t    i_res;
    logic [2:0]  i_funct3;
    logic [4:0]  i_alu_sub;
    res_src_t    i_res_src;
    logic        i_reg_write;
    logic        i_store;
    logic [4:0]  i_rd;
    logic [31:0] i_reg_data2;
    logic        i_inst_jal_jalr;
    logic        i_inst_branch;
    logic [31:0] i_pc;
    logic [31:0] i_pc_next;
    logic [31:0] i_pc_target;
    logic        i_branch_pred;
    logic        i_to_trap;
    logic [31:0] o_result;
    logic [31:0] o_store_data;
    logic [4:0]  o_rd;
    logic        o_reg_write;
    logic        o_store;
    res_src_t    o_res_src;
    logic [2:0]  o_funct3;
    logic        o_to_trap;
    logic        o_pc_change;
    logic [31:0] o_pc_new;
    logic        o_bp_update;
    logic        o_bp_taken;
    logic [31:0] o_bp_pc;

    int n_cmp = 0;
    int n_bad = 0;

    rv_alu2 #(.IADDR_SPACE_BITS(32)) dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .i_stall         (i_stall),
        .i_flush         (i_flush),
        .i_op1           (i_op1),
        .i_op2           (i_op2),
        .i_res           (i_res),
        .i_funct3        (i_funct3),
        .i_alu_sub       (i_alu_sub),
        .i_res_src       (i_res_src),
        .i_reg_write     (i_reg_write),
        .i_store         (i_store),
        .i_rd            (i_rd),
        .i_reg_data2     (i_reg_data2),
        .i_inst_jal_jalr (i_inst_jal_jalr),
        .i_inst_branch   (i_inst_branch),
        .i_pc            (i_pc),
        .i_pc_next       (i_pc_next),
        .i_pc_target     (i_pc_target),
        .i_branch_pred   (i_branch_pred),
        .i_to_trap       (i_to_trap),
        .o_result        (o_result),
        .o_store_data    (o_store_data),
        .o_rd            (o_rd),
        .o_reg_write     (o_reg_write),
        .o_store         (o_store),
        .o_res_src       (o_res_src),
        .o_funct3        (o_funct3),
        .o_to_trap       (o_to_trap),
        .o_pc_change     (o_pc_change),
        .o_pc_new        (o_pc_new),
        .o_bp_update     (o_bp_update),
        .o_bp_taken      (o_bp_taken),
        .o_bp_pc         (o_bp_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_stall = 0; i_flush = 0;
        i_op1 = 0; i_op2 = 0; i_res = '0; i_funct3 = 0; i_alu_sub = 0;
        i_res_src = RES_ALU; i_reg_write = 0; i_store = 0; i_rd = 0; i_reg_data2 = 0;
        i_inst_jal_jalr = 0; i_inst_branch = 0;
        i_pc = 0; i_pc_next = 0; i_pc_target = 0; i_branch_pred = 0; i_to_trap = 0;
    endtask

    // Returns 1 time unit after the rising edge so outputs are sampled away from it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        idle();
        i_reset_n = 0;
        i_op1 = 32'h1234; i_res.arith = 1; i_reg_write = 1; i_inst_branch = 1;
        step(); step();
        chk("rst_result",    o_result, 32'h0);
        chk("rst_regwrite",  32'(o_reg_write), 32'h0);
        chk("rst_pcchange",  32'(o_pc_change), 32'h0);
        chk("rst_bpupdate",  32'(o_bp_update), 32'h0);
        #3 i_reset_n = 1;

        // 5 - 7
        idle(); i_op1 = 5; i_op2 = 7; i_res.arith = 1; i_alu_sub = 5'b00001;
        i_reg_write = 1; i_rd = 5'd3; i_reg_data2 = 32'hCAFE0001; i_res_src = RES_MEM;
        step();
        chk("sub",        o_result, 32'hFFFFFFFE);
        chk("sub_rd",     32'(o_rd), 32'd3);
        chk("sub_rw",     32'(o_reg_write), 32'd1);
        chk("sub_sdata",  o_store_data, 32'hCAFE0001);
        chk("sub_ressrc", 32'(o_res_src), 32'(RES_MEM));
        chk("sub_nobp",   32'(o_bp_update), 32'd0);

        idle(); i_op1 = 32'hFFFFFFFF; i_op2 = 2; i_res.arith = 1;
        step();
        chk("add_wrap", o_result, 32'h1);

        idle(); i_op1 = 32'h80000000; i_op2 = 4; i_res.shift = 1; i_funct3 = F3_SRX; i_alu_sub = 5'b00001;
        step();
        chk("sra", o_result, 32'hF8000000);
        idle(); i_op1 = 32'h80000000; i_op2 = 4; i_res.shift = 1; i_funct3 = F3_SRX; i_alu_sub = 5'b11110;
        step();
        chk("srl_resv_bits", o_result, 32'h08000000);
        idle(); i_op1 = 1; i_op2 = 32'h25; i_res.shift = 1; i_funct3 = F3_SLL;
        step();
        chk("sll_shamt5", o_result, 32'h20);

        idle(); i_op1 = 32'hF0F0; i_op2 = 32'hFF00; i_res.lgc = 1; i_funct3 = F3_XOR;
        step();
        chk("xor", o_result, 32'h0FF0);
        i_funct3 = F3_OR; step();
        chk("or", o_result, 32'hFFF0);
        i_funct3 = F3_AND; step();
        chk("and", o_result, 32'hF000);

        idle(); i_op1 = 32'hFFFFFFFF; i_op2 = 1; i_res.slt = 1; i_funct3 = F3_SLT;
        step();
        chk("slt", o_result, 32'h1);
        i_funct3 = F3_SLTU; step();
        chk("sltu", o_result, 32'h0);
        idle(); i_op1 = 9; i_op2 = 9; step();
        chk("nosel", o_result, 32'h0);

        // Mispredicted BEQ taken
        idle(); i_op1 = 3; i_op2 = 3; i_inst_branch = 1; i_funct3 = F3_BEQ;
        i_pc = 32'h100; i_pc_next = 32'h104; i_pc_target = 32'h200;
        step();
        chk("beq_change", 32'(o_pc_change), 32'd1);
        chk("beq_new",    o_pc_new, 32'h200);
        chk("beq_taken",  32'(o_bp_taken), 32'd1);
        chk("beq_bpupd",  32'(o_bp_update), 32'd1);
        chk("beq_bppc",   o_bp_pc, 32'h100);
        idle(); step();
        chk("beq_oneshot", 32'(o_pc_change), 32'd0);

        // Correctly predicted BLT
        idle(); i_op1 = 32'hFFFFFFFF; i_op2 = 1; i_inst_branch = 1; i_funct3 = F3_BLT; i_branch_pred = 1;
        i_pc = 32'h100; i_pc_next = 32'h200; i_pc_target = 32'h200;
        step();
        chk("blt_change", 32'(o_pc_change), 32'd0);
        chk("blt_bpupd",  32'(o_bp_update), 32'd1);
        chk("blt_taken",  32'(o_bp_taken), 32'd1);

        // BLTU with same operands: not taken, predicted taken -> redirect to pc+4
        i_funct3 = F3_BLTU; step();
        chk("bltu_change", 32'(o_pc_change), 32'd1);
        chk("bltu_new",    o_pc_new, 32'h104);
        chk("bltu_taken",  32'(o_bp_taken), 32'd0);

        // funct3 010 never taken even when operands match
        idle(); i_op1 = 3; i_op2 = 3; i_inst_branch = 1; i_funct3 = 3'b010;
        i_pc = 32'h100; i_pc_next = 32'h104; i_pc_target = 32'h200;
        step();
        chk("f3_010_taken",  32'(o_bp_taken), 32'd0);
        chk("f3_010_change", 32'(o_pc_change), 32'd0);

        // JALR with odd target
        idle(); i_inst_jal_jalr = 1; i_res.arith = 1; i_op1 = 32'h300; i_op2 = 1;
        i_pc = 32'h40; i_pc_next = 32'h44; i_pc_target = 32'h301;
        step();
        chk("jalr_link",   o_result, 32'h44);
        chk("jalr_new",    o_pc_new, 32'h300);
        chk("jalr_change", 32'(o_pc_change), 32'd1);
        i_to_trap = 1; step();
        chk("trap_nochange", 32'(o_pc_change), 32'd0);
        chk("trap_pass",     32'(o_to_trap), 32'd1);
        chk("trap_bpupd",    32'(o_bp_update), 32'd1);

        // Stall during a mispredict
        idle(); i_op1 = 3; i_op2 = 3; i_res.arith = 1; i_inst_branch = 1; i_funct3 = F3_BEQ;
        i_reg_write = 1; i_pc = 32'h100; i_pc_next = 32'h104; i_pc_target = 32'h200;
        step();
        chk("stl_pre_change", 32'(o_pc_change), 32'd1);
        chk("stl_pre_result", o_result, 32'd6);
        i_stall = 1; i_op1 = 100;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stl_change", 32'(o_pc_change), 32'd0);
            chk("stl_bpupd",  32'(o_bp_update), 32'd0);
            chk("stl_result", o_result, 32'd6);
        end
        chk("stl_regwrite", 32'(o_reg_write), 32'd1);
        i_flush = 1; step();
        chk("fls_regwrite", 32'(o_reg_write), 32'd0);
        chk("fls_result",   o_result, 32'd6);
        chk("fls_pcnew",    o_pc_new, 32'h200);

        // Asynchronous reset mid-cycle
        idle(); i_op1 = 1; i_op2 = 2; i_res.arith = 1; i_reg_write = 1; i_inst_jal_jalr = 1;
        i_pc = 32'h40; i_pc_next = 32'h0; i_pc_target = 32'h80;
        step();
        chk("pre_rst_change", 32'(o_pc_change), 32'd1);
        #2 i_reset_n = 0;
        #1;
        chk("arst_result",   o_result, 32'h0);
        chk("arst_regwrite", 32'(o_reg_write), 32'd0);
        chk("arst_change",   32'(o_pc_change), 32'd0);
        chk("arst_pcnew",    o_pc_new, 32'h0);
        chk("arst_bppc",     o_bp_pc, 32'h0);
        #1 i_reset_n = 1;
        idle(); i_op1 = 5; i_op2 = 7; i_res.arith = 1; i_reg_write = 1;
        step();
        chk("post_rst_add", o_result, 32'd12);
        chk("post_rst_rw",  32'(o_reg_write), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_alu2.md
Name: rv_alu2

Overview:
- Execute stage directly downstream of the ALU operand-select stage.
- Consumes its registered operands and control, computes the integer result, and resolves branches, JAL, JALR and MRET.
- Compares the actual next PC against the predicted one and issues a registered redirect/flush plus a branch-predictor update.
- Registers the result and control for the memory/writeback stage.

Parameters:
- IADDR_SPACE_BITS, 32, width of instruction-address signals (16..32).

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_stall  in  1  hold all output registers
- i_flush  in  1  kill the instruction in this stage
- i_op1, i_op2  in  32  ALU operands
- i_res  in  alu_res_t  one-hot result select: arith, logic, shift, slt
- i_funct3  in  3  operation / branch condition
- i_alu_sub  in  5  bit0 = SUB/SRA; bits 4:1 reserved, ignored
- i_res_src  in  res_src_t  writeback source, passed through
- i_reg_write, i_store  in  1  control, passed through
- i_rd  in  5  destination register
- i_reg_data2  in  32  store data
- i_inst_jal_jalr, i_inst_branch  in  1  control-flow class
- i_pc, i_pc_next, i_pc_target  in  IADDR_SPACE_BITS  current PC, predicted next PC, computed target
- i_branch_pred  in  1  predictor said taken
- i_to_trap  in  1  trap pending, passed through
- o_result  out  32  ALU result, or link address for jumps
- o_store_data  out  32  registered i_reg_data2
- o_rd, o_reg_write, o_store, o_res_src, o_funct3, o_to_trap  out  as inputs  registered pass-through
- o_pc_change  out  1  one-cycle redirect strobe
- o_pc_new  out  IADDR_SPACE_BITS  redirect address
- o_bp_update  out  1  predictor update strobe
- o_bp_taken  out  1  resolved direction
- o_bp_pc  out  IADDR_SPACE_BITS  PC of the resolved instruction

Behaviour:
- Reset: all outputs 0, asynchronously. Reset wins over flush and stall.
- Latency: 1 cycle; inputs sampled on the rising edge, outputs registered.
- Priority: i_flush > i_stall.
  - Flush zeroes o_reg_write, o_store, o_res_src, o_to_trap, o_pc_change, o_bp_update; datapath registers keep old values.
  - Stall holds every register, but forces o_pc_change = 0 and o_bp_update = 0 so no strobe repeats.
- Arithmetic (i_res.arith): add, or subtract when alu_sub[0]=1; result modulo 2^32.
- Logic (i_res.logic): funct3 100 = XOR, 110 = OR, 111 = AND.
- Shift (i_res.shift): shift amount = op2[4:0].
  - funct3 001 = SLL.
  - funct3 101 = SRL, or SRA when alu_sub[0]=1.
- SLT (i_res.slt): funct3 010 = signed compare, 011 = unsigned; result zero-extended to 32 bits.
- No select bit set: result = 0.
- Jumps: when i_inst_jal_jalr=1, result = i_pc + 4, zero-extended.
- Branch condition by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 never taken.
- taken = i_inst_jal_jalr | (i_inst_branch & cond).
- actual_next = taken ? {i_pc_target[IADDR_SPACE_BITS-1:1], 1'b0} : i_pc + 4 (wraps at address space).
- Redirect: o_pc_change = (i_inst_jal_jalr | i_inst_branch) & (actual_next != i_pc_next) & !i_to_trap; o_pc_new = actual_next.
- Predictor update: o_bp_update = i_inst_branch | i_inst_jal_jalr; o_bp_taken = taken; o_bp_pc = i_pc.
- The stage issues no self-suppression; upstream stages are flushed by the consumer of o_pc_change.

Decomposition:
- Shared package: alu_res_t, res_src_t, funct3 branch/ALU encodings, ALU_SUB_BIT index.
- One sub-module, rv_branch_cmp: combinational condition evaluation from funct3 and operands; instantiated once.

Test Plan:
- Arithmetic and shift: op1=5, op2=7, arith, sub=1 -> o_result=0xFFFFFFFE next cycle; op1=0x80000000, op2=4, SRA -> 0xF8000000.
- Mispredicted branch: BEQ, op1=op2=3, pc=0x100, pc_next=0x104, target=0x200 -> o_pc_change=1, o_pc_new=0x200, o_bp_taken=1 for exactly one cycle.
- Correctly predicted branch: BLT, op1=-1, op2=1, pc_next=0x200=target -> o_pc_change=0, o_bp_update=1.
- JALR target LSB: target=0x301, pc=0x40 -> o_result=0x44, o_pc_new=0x300.
- Stall held 3 cycles during a mispredict -> o_pc_change pulses once only, o_result stable; flush together with stall -> o_reg_write=0.
- Async reset asserted mid-cycle -> all outputs 0 immediately, without waiting for a clock edge; first instruction after deassertion resolves normally.
